// File: rtl/lsu_sequencer.sv
// lsu_sequencer
// Initiator side of the data-memory port. Takes one load/store request at a
// time from the core, splits halfwords and misaligned words into byte beats,
// drives the memory beat interface, reassembles load bytes and returns a
// one-cycle response with sign/zero-extended data.
//
// Ports:
//   clk_i, rst_ni                  clock (rising edge), async active-low reset
//   req_valid_i / req_ready_o      request handshake (ready only in IDLE)
//   req_we_i, req_size_i           store flag, size (0 byte, 1 half, 2 word)
//   req_unsigned_i                 load zero-extend select
//   req_addr_i, req_wdata_i        byte address, right-aligned store data
//   resp_valid_o, resp_err_o       completion pulse, rejection flag
//   resp_rdata_o                   extended load data (0 for stores/errors)
//   mem_we_o, mem_byte_op_o        memory write enable, byte-beat select
//   mem_addr_o, mem_wd_o           memory byte address, write data
//   mem_rd_i                       memory read data (combinational)
module lsu_sequencer #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    BYTE_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] END_ADDRESS = 'h1FFFF
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [DATA_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   output logic                  resp_err_o,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  mem_we_o,
   output logic                  mem_byte_op_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wd_o,
   input  logic [DATA_WIDTH-1:0] mem_rd_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [DATA_WIDTH:0] ONE = 1;

   state_t                state_q, state_d;
   logic                  we_q, unsigned_q, err_q;
   logic [1:0]            size_q, beat_q;
   logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;

   logic [DATA_WIDTH:0]   req_nbytes, req_last;
   logic                  req_err;
   logic                  word_beat;
   logic [1:0]            last_beat;

   function automatic logic [DATA_WIDTH-1:0] extend_load(
      input logic [DATA_WIDTH-1:0] raw,
      input logic [1:0]            size,
      input logic                  uns
   );
      logic sgn;
      case (size)
         2'd0: begin
            sgn = ~uns & raw[BYTE_WIDTH-1];
            return {{(DATA_WIDTH-BYTE_WIDTH){sgn}}, raw[BYTE_WIDTH-1:0]};
         end
         2'd1: begin
            sgn = ~uns & raw[2*BYTE_WIDTH-1];
            return {{(DATA_WIDTH-2*BYTE_WIDTH){sgn}}, raw[2*BYTE_WIDTH-1:0]};
         end
         default: return raw;
      endcase
   endfunction

   // Range check is one bit wider than the address so a request that wraps
   // past the top of the address space is rejected rather than aliased.
   always_comb begin
      case (req_size_i)
         2'd0:    req_nbytes = ONE;
         2'd1:    req_nbytes = 2 * ONE;
         default: req_nbytes = 4 * ONE;
      endcase
      req_last = {1'b0, req_addr_i} + req_nbytes - ONE;
      req_err  = (req_size_i == 2'd3) || (req_last > {1'b0, END_ADDRESS});
   end

   // Only an aligned word travels as a single word beat; everything else is
   // a sequence of byte beats.
   always_comb begin
      word_beat = (size_q == 2'd2) && (addr_q[1:0] == 2'b00);
      if (word_beat || size_q == 2'd0) last_beat = 2'd0;
      else if (size_q == 2'd1)         last_beat = 2'd1;
      else                             last_beat = 2'd3;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         unsigned_q <= 1'b0;
         err_q      <= 1'b0;
         size_q     <= 2'd0;
         beat_q     <= 2'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  we_q       <= req_we_i;
                  size_q     <= req_size_i;
                  unsigned_q <= req_unsigned_i;
                  addr_q     <= req_addr_i;
                  wdata_q    <= req_wdata_i;
                  err_q      <= req_err;
                  beat_q     <= 2'd0;
                  rdata_q    <= '0;
               end
            end
            ACCESS: begin
               beat_q <= beat_q + 2'd1;
               if (!we_q) begin
                  if (word_beat) rdata_q <= mem_rd_i;
                  else begin
                     for (int i = 0; i < 4; i++)
                        if (beat_q == 2'(i))
                           rdata_q[i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_rd_i[BYTE_WIDTH-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid_i) state_d = req_err ? RESP : ACCESS;
         ACCESS:  if (beat_q == last_beat) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory outputs are held at zero outside ACCESS so nothing is written
   // while idle, responding or in reset.
   always_comb begin
      req_ready_o   = (state_q == IDLE);
      resp_valid_o  = 1'b0;
      resp_err_o    = 1'b0;
      resp_rdata_o  = '0;
      mem_we_o      = 1'b0;
      mem_byte_op_o = 1'b0;
      mem_addr_o    = '0;
      mem_wd_o      = '0;
      case (state_q)
         ACCESS: begin
            mem_we_o      = we_q;
            mem_byte_op_o = ~word_beat;
            if (word_beat) begin
               mem_addr_o = addr_q;
               mem_wd_o   = wdata_q;
            end else begin
               mem_addr_o = addr_q + DATA_WIDTH'(beat_q);
               for (int i = 0; i < 4; i++)
                  if (beat_q == 2'(i))
                     mem_wd_o = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}},
                                 wdata_q[i*BYTE_WIDTH +: BYTE_WIDTH]};
            end
         end
         RESP: begin
            resp_valid_o = 1'b1;
            resp_err_o   = err_q;
            if (!err_q && !we_q)
               resp_rdata_o = extend_load(rdata_q, size_q, unsigned_q);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed testbench for lsu_sequencer with a byte-addressable memory model.
module tb_lsu_sequencer;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_we, mem_byte_op;
   logic [31:0] mem_addr, mem_wd, mem_rd;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [0:32'h1FFFF];

   logic        rec_we   [1:8];
   logic        rec_bop  [1:8];
   logic [31:0] rec_addr [1:8];
   logic [31:0] rec_wd   [1:8];
   logic        rec_rdy  [1:8];
   int          obs_lat, obs_wait;
   logic        obs_err;
   logic [31:0] obs_rdata;

   always #5 clk = ~clk;

   lsu_sequencer #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .END_ADDRESS(32'h1FFFF)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_size_i(req_size), .req_unsigned_i(req_unsigned),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_err_o(resp_err), .resp_rdata_o(resp_rdata),
      .mem_we_o(mem_we), .mem_byte_op_o(mem_byte_op), .mem_addr_o(mem_addr),
      .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
   );

   // Little-endian memory: combinational read, write on the falling edge.
   always_comb begin
      mem_rd = '0;
      if (mem_byte_op && mem_addr <= 32'h1FFFF)
         mem_rd = {24'b0, mem[mem_addr[16:0]]};
      else if (!mem_byte_op && mem_addr <= 32'h1FFFC)
         mem_rd = {mem[mem_addr[16:0] + 17'd3], mem[mem_addr[16:0] + 17'd2],
                   mem[mem_addr[16:0] + 17'd1], mem[mem_addr[16:0]]};
   end

   always @(negedge clk) begin
      if (mem_we && mem_byte_op && mem_addr <= 32'h1FFFF)
         mem[mem_addr[16:0]] = mem_wd[7:0];
      else if (mem_we && !mem_byte_op && mem_addr <= 32'h1FFFC) begin
         mem[mem_addr[16:0]]          = mem_wd[7:0];
         mem[mem_addr[16:0] + 17'd1]  = mem_wd[15:8];
         mem[mem_addr[16:0] + 17'd2]  = mem_wd[23:16];
         mem[mem_addr[16:0] + 17'd3]  = mem_wd[31:24];
      end
   end

   // Issues one request and records the memory interface for each cycle
   // after acceptance (cycle 1 starts at the acceptance edge) until the
   // response pulse. Leaves time at #1 after the edge of the response cycle.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
      obs_wait = 0;
      while (!req_ready && obs_wait < 20) begin
         @(posedge clk); #1;
         obs_wait++;
      end
      if (!req_ready) begin
         errors++;
         $display("FAIL ready_timeout got=0 want=1");
      end
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      obs_lat = 0; obs_err = 1'bx; obs_rdata = 'x;
      for (int c = 1; c <= 8; c++) begin
         rec_we[c] = mem_we; rec_bop[c] = mem_byte_op; rec_addr[c] = mem_addr;
         rec_wd[c] = mem_wd; rec_rdy[c] = req_ready;
         if (resp_valid) begin
            obs_lat = c; obs_err = resp_err; obs_rdata = resp_rdata;
            break;
         end
         @(posedge clk); #1;
      end
      if (obs_lat == 0) begin
         errors++;
         $display("FAIL resp_timeout addr=%h no resp_valid within 8 cycles", addr);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({req_ready, resp_valid, resp_err, mem_we, mem_byte_op} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl got=%b want=10000",
                  {req_ready, resp_valid, resp_err, mem_we, mem_byte_op});
      end
      checks++;
      if ({mem_addr, mem_wd, resp_rdata} !== 96'h0) begin
         errors++;
         $display("FAIL reset_data got=%h %h %h want=0", mem_addr, mem_wd, resp_rdata);
      end
      @(negedge clk) rst_ni = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_aligned_word();
      do_req(1'b1, 2'd2, 1'b0, 32'h10000, 32'hDEADBEEF);
      checks++;
      if ({obs_lat, obs_err, obs_rdata} !== {32'd2, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL sw_resp got lat=%0d err=%b rd=%h want lat=2 err=0 rd=0",
                  obs_lat, obs_err, obs_rdata);
      end
      checks++;
      if ({rec_we[1], rec_bop[1], rec_addr[1], rec_wd[1]} !== {1'b1, 1'b0, 32'h10000, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL sw_beat got we=%b bop=%b a=%h wd=%h want we=1 bop=0 a=10000 wd=deadbeef",
                  rec_we[1], rec_bop[1], rec_addr[1], rec_wd[1]);
      end
      do_req(1'b0, 2'd2, 1'b0, 32'h10000, 32'h0);
      checks++;
      if ({obs_lat, obs_rdata, rec_we[1], rec_bop[1]} !== {32'd2, 32'hDEADBEEF, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL lw_aligned got lat=%0d rd=%h we=%b bop=%b want lat=2 rd=deadbeef we=0 bop=0",
                  obs_lat, obs_rdata, rec_we[1], rec_bop[1]);
      end
   endtask

   task automatic test_split_half();
      do_req(1'b1, 2'd1, 1'b0, 32'h10003, 32'h0000A5F0);
      checks++;
      if (obs_lat !== 3) begin
         errors++;
         $display("FAIL sh_latency got=%0d want=3", obs_lat);
      end
      checks++;
      if ({rec_we[1], rec_bop[1], rec_addr[1], rec_wd[1], rec_we[2], rec_bop[2], rec_addr[2], rec_wd[2]}
          !== {1'b1, 1'b1, 32'h10003, 32'h000000F0, 1'b1, 1'b1, 32'h10004, 32'h000000A5}) begin
         errors++;
         $display("FAIL sh_beats got %h/%h %h/%h want 10003/f0 10004/a5",
                  rec_addr[1], rec_wd[1], rec_addr[2], rec_wd[2]);
      end
      do_req(1'b0, 2'd1, 1'b0, 32'h10003, 32'h0);
      checks++;
      if (obs_rdata !== 32'hFFFFA5F0) begin
         errors++;
         $display("FAIL lh_signed got=%h want=ffffa5f0", obs_rdata);
      end
      do_req(1'b0, 2'd1, 1'b1, 32'h10003, 32'h0);
      checks++;
      if (obs_rdata !== 32'h0000A5F0) begin
         errors++;
         $display("FAIL lhu got=%h want=0000a5f0", obs_rdata);
      end
   endtask

   task automatic test_misaligned_word();
      do_req(1'b1, 2'd2, 1'b0, 32'h10000, 32'h44332211);
      do_req(1'b1, 2'd0, 1'b0, 32'h10004, 32'h00000055);
      do_req(1'b0, 2'd2, 1'b0, 32'h10001, 32'h0);
      checks++;
      if ({obs_lat, obs_rdata} !== {32'd5, 32'h55443322}) begin
         errors++;
         $display("FAIL lw_misaligned got lat=%0d rd=%h want lat=5 rd=55443322", obs_lat, obs_rdata);
      end
      checks++;
      if ({rec_addr[1], rec_addr[2], rec_addr[3], rec_addr[4]}
          !== {32'h10001, 32'h10002, 32'h10003, 32'h10004}) begin
         errors++;
         $display("FAIL lw_mis_addrs got %h %h %h %h want 10001..10004",
                  rec_addr[1], rec_addr[2], rec_addr[3], rec_addr[4]);
      end
      checks++;
      if ({rec_bop[1], rec_bop[2], rec_bop[3], rec_bop[4], rec_we[1], rec_we[4]} !== 6'b111100) begin
         errors++;
         $display("FAIL lw_mis_ctl got=%b want=111100",
                  {rec_bop[1], rec_bop[2], rec_bop[3], rec_bop[4], rec_we[1], rec_we[4]});
      end
   endtask

   task automatic test_byte_ext();
      do_req(1'b1, 2'd0, 1'b0, 32'h10010, 32'h12345680);
      checks++;
      if (mem[17'h10010] !== 8'h80) begin
         errors++;
         $display("FAIL sb_write got=%h want=80", mem[17'h10010]);
      end
      do_req(1'b0, 2'd0, 1'b0, 32'h10010, 32'h0);
      checks++;
      if ({obs_lat, obs_rdata} !== {32'd2, 32'hFFFFFF80}) begin
         errors++;
         $display("FAIL lb_signed got lat=%0d rd=%h want lat=2 rd=ffffff80", obs_lat, obs_rdata);
      end
      do_req(1'b0, 2'd0, 1'b1, 32'h10010, 32'h0);
      checks++;
      if (obs_rdata !== 32'h00000080) begin
         errors++;
         $display("FAIL lbu got=%h want=00000080", obs_rdata);
      end
      // Last legal byte and last legal aligned word are accepted.
      do_req(1'b0, 2'd0, 1'b1, 32'h1FFFF, 32'h0);
      checks++;
      if ({obs_lat, obs_err, rec_addr[1]} !== {32'd2, 1'b0, 32'h1FFFF}) begin
         errors++;
         $display("FAIL lb_top got lat=%0d err=%b a=%h want lat=2 err=0 a=1ffff",
                  obs_lat, obs_err, rec_addr[1]);
      end
      do_req(1'b0, 2'd2, 1'b0, 32'h1FFFC, 32'h0);
      checks++;
      if ({obs_lat, obs_err} !== {32'd2, 1'b0}) begin
         errors++;
         $display("FAIL lw_top got lat=%0d err=%b want lat=2 err=0", obs_lat, obs_err);
      end
   endtask

   task automatic test_errors();
      logic [31:0] e_addr [3];
      logic [1:0]  e_size [3];
      logic        e_we   [3];
      e_addr[0] = 32'h0001FFFE; e_size[0] = 2'd2; e_we[0] = 1'b0;
      e_addr[1] = 32'h00010000; e_size[1] = 2'd3; e_we[1] = 1'b1;
      e_addr[2] = 32'hFFFFFFFF; e_size[2] = 2'd2; e_we[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         do_req(e_we[k], e_size[k], 1'b0, e_addr[k], 32'hCAFEF00D);
         checks++;
         if ({obs_lat, obs_err, obs_rdata} !== {32'd1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL err_resp%0d got lat=%0d err=%b rd=%h want lat=1 err=1 rd=0",
                     k, obs_lat, obs_err, obs_rdata);
         end
         checks++;
         if ({rec_we[1], rec_bop[1], rec_addr[1], rec_wd[1], rec_rdy[1]} !== 67'h0) begin
            errors++;
            $display("FAIL err_quiet%0d got we=%b bop=%b a=%h wd=%h rdy=%b want all 0",
                     k, rec_we[1], rec_bop[1], rec_addr[1], rec_wd[1], rec_rdy[1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_req(1'b1, 2'd2, 1'b0, 32'h10020, 32'h11223344);
      checks++;
      if ({req_ready, rec_rdy[1]} !== 2'b00) begin
         errors++;
         $display("FAIL busy_ready got=%b want=00", {req_ready, rec_rdy[1]});
      end
      do_req(1'b0, 2'd2, 1'b0, 32'h10020, 32'h0);
      checks++;
      if ({obs_wait, obs_lat, obs_rdata} !== {32'd1, 32'd2, 32'h11223344}) begin
         errors++;
         $display("FAIL b2b got wait=%0d lat=%0d rd=%h want wait=1 lat=2 rd=11223344",
                  obs_wait, obs_lat, obs_rdata);
      end
   endtask

   task automatic test_reset_mid_op();
      int seen_resp;
      do_req(1'b1, 2'd2, 1'b0, 32'h10000, 32'h04030201);
      do_req(1'b1, 2'd0, 1'b0, 32'h10004, 32'h00000005);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h10001; req_wdata = 32'hA1B2C3D4;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if ({mem_we, mem_addr, mem_wd} !== {1'b1, 32'h10003, 32'h000000B2}) begin
         errors++;
         $display("FAIL mid_beat2 got we=%b a=%h wd=%h want we=1 a=10003 wd=b2", mem_we, mem_addr, mem_wd);
      end
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({mem_we, mem_byte_op, mem_addr, mem_wd, resp_valid, req_ready} !== {66'h0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL async_reset got we=%b bop=%b a=%h wd=%h rv=%b rdy=%b want 0 0 0 0 0 1",
                  mem_we, mem_byte_op, mem_addr, mem_wd, resp_valid, req_ready);
      end
      seen_resp = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (resp_valid) seen_resp++;
      end
      @(negedge clk) rst_ni = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         if (resp_valid) seen_resp++;
      end
      checks++;
      if ({seen_resp, req_ready} !== {32'd0, 1'b1}) begin
         errors++;
         $display("FAIL post_reset got resp=%0d rdy=%b want resp=0 rdy=1", seen_resp, req_ready);
      end
      checks++;
      if ({mem[17'h10000], mem[17'h10001], mem[17'h10002], mem[17'h10003], mem[17'h10004]}
          !== 40'h01D4C30405) begin
         errors++;
         $display("FAIL partial_store got %h %h %h %h %h want 01 d4 c3 04 05",
                  mem[17'h10000], mem[17'h10001], mem[17'h10002], mem[17'h10003], mem[17'h10004]);
      end
   endtask

   initial begin
      test_reset();
      test_aligned_word();
      test_split_half();
      test_misaligned_word();
      test_byte_ext();
      test_errors();
      test_back_to_back();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lsu_sequencer.md
Name: lsu_sequencer

Overview:
Initiator side of the data-memory port. Accepts one load/store request at a time from the core and drives the memory's we/byte_op/addr/wd/rd interface. Byte and aligned-word accesses map to one memory beat. Halfwords and misaligned words are split into byte beats. Read bytes are reassembled and sign- or zero-extended before a one-cycle response pulse.

Parameters:
DATA_WIDTH, 32, data/address width; must equal 4*BYTE_WIDTH
BYTE_WIDTH, 8, width of one memory byte lane
END_ADDRESS, 32'h1FFFF, highest legal byte address of the memory

Ports:
clk_i  in  1  clock, rising-edge for all state
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request present
req_ready_o  out  1  sequencer can accept (high only in IDLE)
req_we_i  in  1  1=store, 0=load
req_size_i  in  2  0=byte, 1=half, 2=word, 3=reserved
req_unsigned_i  in  1  loads: 1=zero-extend, 0=sign-extend
req_addr_i  in  DATA_WIDTH  byte address
req_wdata_i  in  DATA_WIDTH  store data, right-aligned
resp_valid_o  out  1  one-cycle completion pulse
resp_err_o  out  1  request rejected (qualified by resp_valid_o)
resp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores/errors
mem_we_o  out  1  memory write enable
mem_byte_op_o  out  1  1=byte beat, 0=word beat
mem_addr_o  out  DATA_WIDTH  memory byte address
mem_wd_o  out  DATA_WIDTH  memory write data
mem_rd_i  in  DATA_WIDTH  memory read data, combinational from mem_addr_o

Behaviour:
- Reset (async, rst_ni=0): state IDLE, beat counter 0, capture regs 0. Outputs: req_ready_o=1, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_we_o=0, mem_byte_op_o=0, mem_addr_o=0, mem_wd_o=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready_o=1. On a rising edge with req_valid_i=1, capture we/size/unsigned/addr/wdata. Request inputs are ignored after capture.
- Beat count N: byte=1; half=2; word with addr[1:0]=0 → 1 word beat; word misaligned → 4. Byte beats apply to halfwords at any alignment.
- Error check at acceptance: error if size=3, or if addr+N_bytes-1 > END_ADDRESS, computed at DATA_WIDTH+1 bits so wrap past 2^32 is an error. N_bytes is 1, 2 or 4.
  - On error: go directly to RESP with resp_err_o=1. No memory beat is issued.
  - Otherwise go to ACCESS with beat=0.
- ACCESS: one beat per cycle.
  - Beat i drives mem_addr_o=addr+i (word beat: addr) and mem_byte_op_o=(word beat ? 0 : 1).
  - mem_we_o=captured we. mem_wd_o=full wdata for a word beat. For byte beat i, mem_wd_o={zeros, wdata[8i+7:8i]}.
  - Memory commits writes on the falling edge inside the beat cycle.
- Loads: at the rising edge ending beat i, capture mem_rd_i[7:0] into assembly byte i (byte beat) or all of mem_rd_i (word beat).
- After beat N-1, go to RESP.
- RESP: resp_valid_o=1 for exactly one cycle, all mem_* outputs 0, req_ready_o=0, then IDLE.
- Extension: byte loads use bit 7 and halfword loads use bit 15 when req_unsigned_i=0. Unused upper bits are 0 when unsigned. Word loads are not extended.
- Latency, acceptance edge to resp_valid_o cycle: N+1 cycles; error case 1 cycle. Back-to-back throughput: one request per N+2 cycles.
- Outside ACCESS, all mem_* outputs are 0, so no spurious writes occur.
- Reset mid-ACCESS: abort immediately and return to IDLE with no response. Bytes already written by earlier beats of a split store remain written; this is accepted.

Test Plan:
- Aligned store then load: SW addr=0x10000 wdata=0xDEADBEEF → one beat with byte_op=0, we=1. Then LW 0x10000 → resp_rdata=0xDEADBEEF two cycles after acceptance.
- Split halfword: SH addr=0x10003 wdata=0x0000A5F0 → beats at 0x10003 (0xF0) and 0x10004 (0xA5). Then LH signed from 0x10003 → 0xFFFFA5F0; LHU → 0x0000A5F0.
- Misaligned word: LW addr=0x10001 over bytes 11,22,33,44,55 at 0x10000..4 → four byte beats at 0x10001..0x10004, resp_rdata=0x55443322, resp_valid 5 cycles after acceptance.
- Byte extension: mem byte 0x80 at 0x10010 → LB returns 0xFFFFFF80; LBU returns 0x00000080.
- Errors: LW at 0x1FFFE, size=3, and addr=0xFFFFFFFF word → resp_valid with resp_err=1 one cycle after acceptance, no mem_we_o or address activity, rdata=0.
- Reset mid-op: misaligned SW at 0x10001 with rst_ni dropped during beat 2 → outputs zero asynchronously. Only bytes 0x10001 and 0x10002 are modified, there is no resp_valid, and req_ready_o=1 after release.
